flag_branch_unit: RTL and testbench

- Consumer end of the ALU's flag interface. Holds the architectural N/Z/V flag register, updated per bit under the ALU's 3-bit write mask.
- Evaluates the 3-bit branch condition code of a branch in decode against those flags. Delivers a registered branch resolution (taken/target) to the fetch stage.
- Handles the hazard where a flag-writing ALU op and a branch present in the same cycle, plus pipeline stall and flush.

---
 rtl/flag_branch_unit.sv | 141 ++++++++++++++
 tb/tb_flag_branch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Flag register and branch resolver at the consumer end of the ALU flag interface.
// Optional macro FLAG_BYPASS_EN merges same-cycle ALU flag writes into the branch evaluation, so a flag/branch conflict never stalls.
module flag_branch_unit #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [2:0]      alu_flag,
  input  logic [2:0]      alu_flag_write,
  input  logic            br_valid,
  input  logic [2:0]      br_ccc,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] br_fall,
  output logic [2:0]      flag_q,
  output logic            br_done,
  output logic            br_taken,
  output logic [PC_W-1:0] br_pc,
  output logic            hazard
);

  typedef enum logic [0:0] {IDLE, PEND} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        pend_ccc_reg;
  logic [PC_W-1:0]   pend_target_reg, pend_fall_reg;
  logic              done_next, taken_next, capture;
  logic [PC_W-1:0]   pc_next;
  logic [2:0]        eff_flags;
  logic              conflict_hold;
  logic              flag_we;
  logic              cond_now, cond_pend;

  // flags are [2]=N [1]=Z [0]=V
  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (ccc)
      3'd0:    cond_met = ~z;
      3'd1:    cond_met = z;
      3'd2:    cond_met = ~z & ~n;
      3'd3:    cond_met = n;
      3'd4:    cond_met = z | ~n;
      3'd5:    cond_met = z | n;
      3'd6:    cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  assign flag_we = alu_valid & ~stall & ~flush;

  always_comb begin
`ifdef FLAG_BYPASS_EN
    eff_flags     = alu_valid ? ((flag_q & ~alu_flag_write) | (alu_flag & alu_flag_write)) : flag_q;
    conflict_hold = 1'b0;
`else
    eff_flags     = flag_q;
    conflict_hold = (state_reg == IDLE) & br_valid & alu_valid & (|alu_flag_write) & ~stall & ~flush;
`endif
  end

  assign hazard    = conflict_hold;
  assign cond_now  = cond_met(br_ccc, eff_flags);
  assign cond_pend = cond_met(pend_ccc_reg, flag_q);

  // Each flag bit has its own write enable from the ALU mask.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          flag_q[gi] <= 1'b0;
        else if (flag_we && alu_flag_write[gi])
          flag_q[gi] <= alu_flag[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    taken_next = br_taken;
    pc_next    = br_pc;
    capture    = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else if (!stall) begin
      case (state_reg)
        IDLE: begin
          if (br_valid) begin
            if (conflict_hold) begin
              state_next = PEND;
              capture    = 1'b1;
            end else begin
              done_next  = 1'b1;
              taken_next = cond_now;
              pc_next    = cond_now ? br_target : br_fall;
            end
          end
        end
        PEND: begin
          state_next = IDLE;
          done_next  = 1'b1;
          taken_next = cond_pend;
          pc_next    = cond_pend ? pend_target_reg : pend_fall_reg;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pend_ccc_reg    <= '0;
      pend_target_reg <= '0;
      pend_fall_reg   <= '0;
      br_done         <= 1'b0;
      br_taken        <= 1'b0;
      br_pc           <= '0;
    end else begin
      state_reg <= state_next;
      br_done   <= done_next;
      br_taken  <= taken_next;
      br_pc     <= pc_next;
      if (flush) begin
        pend_ccc_reg    <= '0;
        pend_target_reg <= '0;
        pend_fall_reg   <= '0;
      end else if (capture) begin
        pend_ccc_reg    <= br_ccc;
        pend_target_reg <= br_target;
        pend_fall_reg   <= br_fall;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit; expectations follow FLAG_BYPASS_EN if defined.
module tb_flag_branch_unit;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_n, stall, flush, alu_valid, br_valid;
  logic [2:0]      alu_flag, alu_flag_write, br_ccc;
  logic [PC_W-1:0] br_target, br_fall;
  logic [2:0]      flag_q;
  logic            br_done, br_taken, hazard;
  logic [PC_W-1:0] br_pc;

  int checks = 0;
  int errors = 0;

  logic [2:0] flags_tab [4];
  logic [7:0] exp_tab   [4];

  flag_branch_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .alu_valid(alu_valid), .alu_flag(alu_flag), .alu_flag_write(alu_flag_write),
    .br_valid(br_valid), .br_ccc(br_ccc), .br_target(br_target), .br_fall(br_fall),
    .flag_q(flag_q), .br_done(br_done), .br_taken(br_taken), .br_pc(br_pc),
    .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; alu_valid = 0; alu_flag = 0; alu_flag_write = 0;
    br_valid = 0; br_ccc = 0;
  endtask

  task automatic set_flags(input logic [2:0] f);
    alu_valid = 1; alu_flag = f; alu_flag_write = 3'b111; br_valid = 0;
    tick();
    alu_valid = 0; alu_flag_write = 0;
  endtask

  // flags=000, ALU writes Z=1 alongside an EQ/NE branch
  task automatic make_conflict(input logic [2:0] ccc);
    set_flags(3'b000);
    alu_valid = 1; alu_flag = 3'b010; alu_flag_write = 3'b010;
    br_valid = 1; br_ccc = ccc;
  endtask

  initial begin
    flags_tab[0] = 3'b000; exp_tab[0] = 8'h95;
    flags_tab[1] = 3'b010; exp_tab[1] = 8'hB2;
    flags_tab[2] = 3'b100; exp_tab[2] = 8'hA9;
    flags_tab[3] = 3'b001; exp_tab[3] = 8'hD5;
    idle_inputs();
    br_target = 16'h0040; br_fall = 16'h0012;
    rst_n = 0;
    #12;
    check("reset_flag_q", 32'(flag_q), 0);
    check("reset_br_done", 32'(br_done), 0);
    check("reset_br_pc", 32'(br_pc), 0);
    check("reset_hazard", 32'(hazard), 0);
    rst_n = 1;
    tick();
    $display("reset released: flag_q=%b br_done=%b", flag_q, br_done);

    // masked writes
    alu_valid = 1; alu_flag = 3'b111; alu_flag_write = 3'b010;
    tick();
    check("mask_write_z", 32'(flag_q), 32'b010);
    $display("mask write 010: flag_q=%b", flag_q);
    alu_flag = 3'b101; alu_flag_write = 3'b101;
    tick();
    check("mask_write_nv", 32'(flag_q), 32'b111);
    $display("mask write 101: flag_q=%b", flag_q);
    alu_valid = 0; alu_flag_write = 0;

    // condition table
    for (int fi = 0; fi < 4; fi++) begin
      set_flags(flags_tab[fi]);
      check("cond_flag_setup", 32'(flag_q), 32'(flags_tab[fi]));
      for (int c = 0; c < 8; c++) begin
        logic [7:0] row;
        logic       t;
        row = exp_tab[fi];
        t = row[c];
        br_valid = 1; br_ccc = 3'(c);
        tick();
        br_valid = 0;
        check("cond_done", 32'(br_done), 1);
        check("cond_taken", 32'(br_taken), 32'(t));
        check("cond_pc", 32'(br_pc), t ? 32'h40 : 32'h12);
        $display("cond flags=%b ccc=%0d: done=%b taken=%b pc=%h", flags_tab[fi], c, br_done, br_taken, br_pc);
      end
    end
    tick();
    check("done_drops", 32'(br_done), 0);

    // stall in IDLE ignores the branch and holds results (last: taken, 0x40)
    stall = 1; br_valid = 1; br_ccc = 3'd1;
    tick();
    check("stall_idle_done", 32'(br_done), 0);
    check("stall_idle_taken", 32'(br_taken), 1);
    check("stall_idle_pc", 32'(br_pc), 32'h40);
    $display("stall idle: done=%b taken=%b pc=%h", br_done, br_taken, br_pc);
    idle_inputs();

    // conflict: NE with Z being set this cycle
    make_conflict(3'd0);
    #1;
`ifdef FLAG_BYPASS_EN
    check("conflict_hazard", 32'(hazard), 0);
    tick();
    idle_inputs();
    check("bypass_done", 32'(br_done), 1);
    check("bypass_taken", 32'(br_taken), 0);
    check("bypass_pc", 32'(br_pc), 32'h12);
    $display("bypass conflict: done=%b taken=%b pc=%h", br_done, br_taken, br_pc);
`else
    check("conflict_hazard", 32'(hazard), 1);
    tick();
    idle_inputs();
    check("conflict_no_done", 32'(br_done), 0);
    check("pend_hazard", 32'(hazard), 0);
    check("conflict_flag", 32'(flag_q), 32'b010);
    tick();
    check("pend_done", 32'(br_done), 1);
    check("pend_taken", 32'(br_taken), 0);
    check("pend_pc", 32'(br_pc), 32'h12);
    $display("pend conflict: done=%b taken=%b pc=%h", br_done, br_taken, br_pc);
    tick();
    check("pend_done_drop", 32'(br_done), 0);

    // stall while pending, ALU write during stall must be ignored
    make_conflict(3'd1);
    tick();
    idle_inputs();
    stall = 1; alu_valid = 1; alu_flag = 3'b111; alu_flag_write = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_stall_done", 32'(br_done), 0);
      check("pend_stall_flag", 32'(flag_q), 32'b010);
      $display("pend stall %0d: done=%b flag_q=%b", i, br_done, flag_q);
    end
    idle_inputs();
    tick();
    check("pend_resume_done", 32'(br_done), 1);
    check("pend_resume_taken", 32'(br_taken), 1);
    check("pend_resume_pc", 32'(br_pc), 32'h40);

    // flush while pending
    make_conflict(3'd1);
    tick();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
    check("pend_flush_done", 32'(br_done), 0);
    tick();
    check("pend_flush_later", 32'(br_done), 0);
    $display("pend flush: done=%b", br_done);
`endif

    // flush squashes flag write and branch
    set_flags(3'b000);
    tick();
    flush = 1; alu_valid = 1; alu_flag = 3'b111; alu_flag_write = 3'b111;
    br_valid = 1; br_ccc = 3'd7;
    tick();
    idle_inputs();
    check("flush_flag", 32'(flag_q), 0);
    check("flush_done", 32'(br_done), 0);
    tick();
    check("flush_done_later", 32'(br_done), 0);
    $display("flush: flag_q=%b done=%b", flag_q, br_done);

    // asynchronous reset (mid-PEND in the default build)
    set_flags(3'b100);
    br_valid = 1; br_ccc = 3'd7;
    tick();
    make_conflict(3'd0);
    tick();
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    check("async_flag", 32'(flag_q), 0);
    check("async_done", 32'(br_done), 0);
    check("async_taken", 32'(br_taken), 0);
    check("async_pc", 32'(br_pc), 0);
    check("async_hazard", 32'(hazard), 0);
    #3;
    rst_n = 1;
    tick();
    check("post_reset_done", 32'(br_done), 0);
    tick();
    check("post_reset_done2", 32'(br_done), 0);
    $display("async reset: flag_q=%b done=%b pc=%h", flag_q, br_done, br_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
